// File: rtl/debug_sequencer_if.sv
// Debug sequencer bus: UART word stream, processor status and the
// control/instruction-memory write outputs. master = sequencer side.
interface debug_sequencer_if #(
    parameter int IM_ADDR_LENGTH = 32,
    parameter int INST_WIDTH     = 32,
    parameter int NBITS          = 32
);
    logic [NBITS-1:0]          rx_Data;
    logic                      rx_done;
    logic                      halt_flag;
    logic                      send_done;
    logic [IM_ADDR_LENGTH-1:0] pc;

    logic                      enable;
    logic                      o_reset;
    logic                      send_flag;
    logic                      IM_We;
    logic [IM_ADDR_LENGTH-1:0] IM_Addr;
    logic [INST_WIDTH-1:0]     IM_Data;
    logic                      prog_error;
    logic [2:0]                dbg_state;

    modport master (
        input  rx_Data, rx_done, halt_flag, send_done, pc,
        output enable, o_reset, send_flag, IM_We, IM_Addr, IM_Data,
               prog_error, dbg_state
    );

    modport slave (
        output rx_Data, rx_done, halt_flag, send_done, pc,
        input  enable, o_reset, send_flag, IM_We, IM_Addr, IM_Data,
               prog_error, dbg_state
    );
endinterface

// File: rtl/debug_sequencer.sv
// Debug controller: loads a program into instruction memory, then runs the
// processor continuously, single-step, N-step or to a breakpoint, and
// requests a state dump whenever a run stops.
module debug_sequencer #(
    parameter int          IM_ADDR_LENGTH = 32,
    parameter int          INST_WIDTH     = 32,
    parameter int          NBITS          = 32,
    parameter int          IM_DEPTH       = 256,
    parameter int          CNT_WIDTH      = 16,
    parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF
) (
    input logic               clk,
    input logic               reset,
    debug_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        RECVPROG = 3'd0,
        RECVMODE = 3'd1,
        RUNPROG  = 3'd2,
        SENDDATA = 3'd3,
        ERROR    = 3'd4
    } state_t;

    localparam logic [31:0] CMD_STEP   = 32'h1000_1000;
    localparam logic [31:0] CMD_CONT   = 32'h1000_2000;
    localparam logic [15:0] TAG_NSTEP  = 16'h1003;
    localparam logic [15:0] TAG_ARM    = 16'h1004;
    localparam logic [15:0] TAG_DISARM = 16'h1005;

    state_t                    state;
    logic [IM_ADDR_LENGTH-1:0] ptr;
    logic [IM_ADDR_LENGTH-1:0] bp;
    logic                      bp_armed;
    logic [CNT_WIDTH-1:0]      cnt;
    logic                      cont;
    logic                      halt_latch;

    logic                      enable_r;
    logic                      o_reset_r;
    logic                      send_r;
    logic                      we_r;
    logic [IM_ADDR_LENGTH-1:0] addr_r;
    logic [INST_WIDTH-1:0]     data_r;
    logic                      perr_r;

    logic [NBITS-1:0]          rx_word;
    logic [31:0]               word32;
    logic                      is_halt;
    logic                      ptr_full;
    logic [CNT_WIDTH-1:0]      n_steps;
    logic                      run_stop;

    assign rx_word  = bus.rx_Data;
    assign word32   = rx_word[31:0];
    assign is_halt  = (word32 == HALT_WORD);
    assign ptr_full = (ptr >= IM_ADDR_LENGTH'(IM_DEPTH));
    assign n_steps  = (rx_word[CNT_WIDTH-1:0] == '0) ? CNT_WIDTH'(1)
                                                     : rx_word[CNT_WIDTH-1:0];
    // cnt==1 means the current enabled cycle is the last requested step
    assign run_stop = bus.halt_flag ||
                      (cont ? (bp_armed && (bus.pc == bp))
                            : (cnt == CNT_WIDTH'(1)));

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RECVPROG;
            ptr        <= '0;
            bp         <= '0;
            bp_armed   <= 1'b0;
            cnt        <= '0;
            cont       <= 1'b0;
            halt_latch <= 1'b0;
            enable_r   <= 1'b0;
            o_reset_r  <= 1'b1;
            send_r     <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            data_r     <= '0;
            perr_r     <= 1'b0;
        end else begin
            we_r <= 1'b0;
            case (state)
                RECVPROG: begin
                    if (bus.rx_done) begin
                        if (ptr_full) begin
                            perr_r <= 1'b1;
                            state  <= ERROR;
                        end else begin
                            we_r   <= 1'b1;
                            addr_r <= ptr;
                            data_r <= rx_word[INST_WIDTH-1:0];
                            if (is_halt) begin
                                ptr       <= '0;
                                o_reset_r <= 1'b0;
                                state     <= RECVMODE;
                            end else begin
                                ptr <= ptr + 1'b1;
                            end
                        end
                    end
                end
                ERROR: begin
                    if (bus.rx_done && is_halt) begin
                        perr_r <= 1'b0;
                        ptr    <= '0;
                        state  <= RECVPROG;
                    end
                end
                RECVMODE: begin
                    if (bus.rx_done) begin
                        if (word32 == CMD_STEP) begin
                            cnt      <= CNT_WIDTH'(1);
                            cont     <= 1'b0;
                            enable_r <= 1'b1;
                            state    <= RUNPROG;
                        end else if (word32 == CMD_CONT) begin
                            cont     <= 1'b1;
                            enable_r <= 1'b1;
                            state    <= RUNPROG;
                        end else if (word32[31:16] == TAG_NSTEP) begin
                            cnt      <= n_steps;
                            cont     <= 1'b0;
                            enable_r <= 1'b1;
                            state    <= RUNPROG;
                        end else if (word32[31:16] == TAG_ARM) begin
                            bp       <= IM_ADDR_LENGTH'(word32[15:0]);
                            bp_armed <= 1'b1;
                        end else if (word32[31:16] == TAG_DISARM) begin
                            bp_armed <= 1'b0;
                        end
                    end
                end
                RUNPROG: begin
                    if (!cont) begin
                        cnt <= cnt - 1'b1;
                    end
                    if (run_stop) begin
                        enable_r   <= 1'b0;
                        send_r     <= 1'b1;
                        halt_latch <= bus.halt_flag;
                        state      <= SENDDATA;
                    end
                end
                SENDDATA: begin
                    if (bus.send_done) begin
                        send_r <= 1'b0;
                        if (halt_latch) begin
                            o_reset_r  <= 1'b1;
                            bp_armed   <= 1'b0;
                            halt_latch <= 1'b0;
                            state      <= RECVPROG;
                        end else begin
                            state <= RECVMODE;
                        end
                    end
                end
                default: state <= RECVPROG;
            endcase
        end
    end

    assign bus.enable     = enable_r;
    assign bus.o_reset    = o_reset_r;
    assign bus.send_flag  = send_r;
    assign bus.IM_We      = we_r;
    assign bus.IM_Addr    = addr_r;
    assign bus.IM_Data    = data_r;
    assign bus.prog_error = perr_r;
    assign bus.dbg_state  = state;
endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: directed scenarios with literal expectations,
// then randomized loads and run commands checked every cycle against a
// behavioural model of the controller.
module tb_debug_sequencer;
    localparam int          DEPTH = 4;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_err    = 0;

    debug_sequencer_if #(.IM_ADDR_LENGTH(32), .INST_WIDTH(32), .NBITS(32)) bus ();

    debug_sequencer #(
        .IM_ADDR_LENGTH(32),
        .INST_WIDTH(32),
        .NBITS(32),
        .IM_DEPTH(DEPTH),
        .CNT_WIDTH(16),
        .HALT_WORD(HALT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_loading, m_error, m_running, m_dumping, m_cont, m_hlatch, m_we;
    int          m_ptr, m_bp, m_left;
    logic [31:0] m_addr, m_data;

    task automatic m_reset();
        m_loading = 1; m_error = 0; m_running = 0; m_dumping = 0;
        m_cont = 0; m_hlatch = 0; m_we = 0;
        m_ptr = 0; m_bp = -1; m_left = 0;
        m_addr = '0; m_data = '0;
    endtask

    task automatic m_start(input bit c, input int k);
        m_running = 1; m_cont = c; m_left = k;
    endtask

    task automatic m_step();
        logic [31:0] w;
        bit stop;
        w = bus.rx_Data;
        m_we = 0;
        if (m_loading) begin
            if (bus.rx_done) begin
                if (m_ptr < DEPTH) begin
                    m_we = 1; m_addr = 32'(m_ptr); m_data = w;
                    if (w == HALT) begin m_ptr = 0; m_loading = 0; end
                    else m_ptr++;
                end else begin
                    m_loading = 0; m_error = 1;
                end
            end
        end else if (m_error) begin
            if (bus.rx_done && w == HALT) begin m_error = 0; m_loading = 1; m_ptr = 0; end
        end else if (m_running) begin
            m_left--;
            stop = bus.halt_flag ||
                   (m_cont ? (m_bp >= 0 && bus.pc == 32'(m_bp)) : (m_left == 0));
            if (stop) begin
                m_running = 0; m_dumping = 1; m_hlatch = bus.halt_flag;
            end
        end else if (m_dumping) begin
            if (bus.send_done) begin
                m_dumping = 0;
                if (m_hlatch) begin m_loading = 1; m_bp = -1; m_hlatch = 0; end
            end
        end else if (bus.rx_done) begin
            if (w == 32'h1000_1000) m_start(0, 1);
            else if (w == 32'h1000_2000) m_start(1, 0);
            else if (w[31:16] == 16'h1003) m_start(0, (w[15:0] == 16'd0) ? 1 : int'(w[15:0]));
            else if (w[31:16] == 16'h1004) m_bp = int'(w[15:0]);
            else if (w[31:16] == 16'h1005) m_bp = -1;
        end
    endtask

    function automatic logic [31:0] m_state();
        if (m_loading) return 32'd0;
        if (m_error)   return 32'd4;
        if (m_running) return 32'd2;
        if (m_dumping) return 32'd3;
        return 32'd1;
    endfunction

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial forever begin
        @(negedge clk);
        chk("enable",     32'(bus.enable),     32'(m_running));
        chk("o_reset",    32'(bus.o_reset),    32'(m_loading || m_error));
        chk("send_flag",  32'(bus.send_flag),  32'(m_dumping));
        chk("prog_error", 32'(bus.prog_error), 32'(m_error));
        chk("dbg_state",  32'(bus.dbg_state),  m_state());
        chk("IM_We",      32'(bus.IM_We),      32'(m_we));
        chk("IM_Addr",    bus.IM_Addr,         m_addr);
        chk("IM_Data",    bus.IM_Data,         m_data);
    end

    // ---------------- monitors and background drivers ----------------
    int          en_cycles = 0;
    logic [31:0] wr_q[$];

    initial forever begin
        @(negedge clk);
        if (bus.enable === 1'b1) en_cycles++;
        if (bus.IM_We === 1'b1) wr_q.push_back(bus.IM_Addr);
    end

    int pc_mode   = 0;   // 0 random small, 1 ramp per enabled cycle, 2 fixed 200
    int ramp_base = 0;
    int halt_pct  = 0;
    bit halt_force = 0;
    bit noise      = 0;

    initial begin
        bus.pc = '0;
        bus.halt_flag = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (pc_mode)
                1:       bus.pc = 32'(en_cycles - ramp_base);
                2:       bus.pc = 32'd200;
                default: bus.pc = 32'($urandom_range(0, 15));
            endcase
            bus.halt_flag = halt_force || ($urandom_range(0, 99) < halt_pct);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_cmd();
        case ($urandom_range(0, 6))
            0: return 32'h1000_1000;
            1: return {16'h1003, 16'($urandom_range(0, 7))};
            2: return 32'h1000_2000;
            3: return {16'h1004, 16'($urandom_range(0, 15))};
            4: return {16'h1005, 16'($urandom)};
            5: return {16'h1001, 16'($urandom_range(0, 16'h0FFF))};
            default: return $urandom & 32'h7FFF_FFFF;
        endcase
    endfunction

    task automatic send_word(input logic [31:0] w, input int gap);
        bus.rx_Data = w;
        bus.rx_done = 1'b1;
        tick();
        bus.rx_done = 1'b0;
        bus.rx_Data = $urandom;
        repeat (gap) tick();
    endtask

    task automatic wait_send(input int budget, input string name);
        int n = 0;
        while (bus.send_flag !== 1'b1 && n < budget) begin
            if (noise) begin
                bus.rx_done   = ($urandom_range(0, 3) == 0);
                bus.rx_Data   = pick_cmd();
                bus.send_done = ($urandom_range(0, 3) == 0);
            end
            tick();
            n++;
        end
        bus.rx_done   = 1'b0;
        bus.send_done = 1'b0;
        chk({name, "_send_flag"}, 32'(bus.send_flag), 32'd1);
    endtask

    task automatic finish_dump();
        repeat ($urandom_range(0, 3)) tick();
        bus.send_done = 1'b1;
        tick();
        bus.send_done = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int b;
        int base;
        bus.rx_Data   = '0;
        bus.rx_done   = 1'b0;
        bus.send_done = 1'b0;
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_state",   32'(bus.dbg_state), 32'd0);
        chk("rst_o_reset", 32'(bus.o_reset),   32'd1);
        chk("rst_enable",  32'(bus.enable),    32'd0);
        chk("rst_IM_Addr", bus.IM_Addr,        32'd0);
        reset = 1'b0;
        tick();

        // Load three words plus the halt marker
        base = wr_q.size();
        send_word(32'h1111_1111, 1);
        send_word(32'h2222_2222, 0);
        send_word(32'h3333_3333, 2);
        send_word(HALT, 0);
        tick();
        chk("load_writes", 32'(wr_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (wr_q.size() > base + i) chk("load_addr", wr_q[base + i], 32'(i));
        chk("load_state",   32'(bus.dbg_state), 32'd1);
        chk("load_o_reset", 32'(bus.o_reset),   32'd0);

        // Single step
        b = en_cycles;
        send_word(32'h1000_1000, 0);
        wait_send(50, "step1");
        chk("step1_enable_cycles", 32'(en_cycles - b), 32'd1);
        finish_dump();
        chk("step1_state",   32'(bus.dbg_state), 32'd1);
        chk("step1_o_reset", 32'(bus.o_reset),   32'd0);

        // N-step 5 and N-step 0
        b = en_cycles;
        send_word(32'h1003_0005, 0);
        wait_send(50, "step5");
        chk("step5_enable_cycles", 32'(en_cycles - b), 32'd5);
        finish_dump();
        b = en_cycles;
        send_word(32'h1003_0000, 0);
        wait_send(50, "step0");
        chk("step0_enable_cycles", 32'(en_cycles - b), 32'd1);
        finish_dump();

        // Breakpoint at 7 with pc ramping 0,1,2,... per enabled cycle
        send_word(32'h1004_0007, 1);
        ramp_base = en_cycles;
        pc_mode = 1;
        send_word(32'h1000_2000, 0);
        wait_send(100, "bp");
        chk("bp_enable_cycles", 32'(en_cycles - ramp_base), 32'd8);
        finish_dump();
        chk("bp_state", 32'(bus.dbg_state), 32'd1);

        // Continuous run ended by halt_flag in the fourth enabled cycle
        pc_mode = 2;
        b = en_cycles;
        send_word(32'h1000_2000, 0);
        repeat (3) tick();
        halt_force = 1'b1;
        wait_send(50, "halt");
        halt_force = 1'b0;
        chk("halt_enable_cycles", 32'(en_cycles - b), 32'd4);
        finish_dump();
        chk("halt_state",   32'(bus.dbg_state), 32'd0);
        chk("halt_o_reset", 32'(bus.o_reset),   32'd1);

        // Overflow: five words into a four-word memory
        base = wr_q.size();
        for (int i = 0; i < 5; i++) send_word(32'h0000_00A0 + 32'(i), 0);
        tick();
        chk("ovf_writes", 32'(wr_q.size() - base), 32'd4);
        for (int i = 0; i < 4; i++)
            if (wr_q.size() > base + i) chk("ovf_addr", wr_q[base + i], 32'(i));
        chk("ovf_prog_error", 32'(bus.prog_error), 32'd1);
        chk("ovf_state",      32'(bus.dbg_state),  32'd4);
        base = wr_q.size();
        send_word(32'h0000_0001, 0);
        send_word(HALT, 0);
        tick();
        chk("ovf_clear_prog_error", 32'(bus.prog_error), 32'd0);
        chk("ovf_clear_state",      32'(bus.dbg_state),  32'd0);
        chk("ovf_clear_writes",     32'(wr_q.size() - base), 32'd0);

        // Asynchronous reset during a long N-step run
        send_word(32'h0000_1234, 0);
        send_word(HALT, 1);
        send_word(32'h1003_03E8, 0);
        repeat (5) tick();
        chk("prerst_enable", 32'(bus.enable), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_enable",  32'(bus.enable),    32'd0);
        chk("midrst_o_reset", 32'(bus.o_reset),   32'd1);
        chk("midrst_state",   32'(bus.dbg_state), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        base = wr_q.size();
        send_word(32'h5555_5555, 0);
        send_word(HALT, 0);
        tick();
        chk("postrst_writes", 32'(wr_q.size() - base), 32'd2);
        if (wr_q.size() > base) chk("postrst_first_addr", wr_q[base], 32'd0);

        // Randomized sessions
        pc_mode  = 0;
        halt_pct = 4;
        noise    = 1'b1;
        for (int it = 0; it < 80; it++) begin
            if (m_loading) begin
                int len = $urandom_range(1, 6);
                for (int i = 0; i < len; i++)
                    send_word($urandom & 32'h7FFF_FFFF, $urandom_range(0, 2));
                send_word(HALT, $urandom_range(0, 2));
            end else if (m_error) begin
                send_word($urandom & 32'h7FFF_FFFF, $urandom_range(0, 1));
                send_word(HALT, $urandom_range(0, 2));
            end else if (m_running || m_dumping) begin
                wait_send(3000, "rnd_run");
                finish_dump();
            end else begin
                send_word(pick_cmd(), 0);
                if (m_running) begin
                    wait_send(3000, "rnd_run");
                    finish_dump();
                end else begin
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        end
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
